// File: rtl/jt10_rom_pkg.sv
// Shared types and constants for the jt10 ADPCM ROM arbiter.
package jt10_rom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } arb_state_t;

  localparam logic [24:0] DEF_ADPCMA_BASE = 25'h0000000;
  localparam logic [24:0] DEF_ADPCMB_BASE = 25'h1000000;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/jt10_rom_chreq.sv
// One ADPCM channel's fetch bookkeeping: held byte, tag of the last completed
// fetch and the address currently issued, plus the pending-request decode.
module jt10_rom_chreq
  import jt10_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        roe_n,
  input  logic [23:0] chan_addr,
  input  logic        issue,
  input  logic        done,
  input  logic [7:0]  dout,
  output logic        pend,
  output logic [7:0]  data
);

  logic [23:0] tag_reg;
  logic [23:0] iss_reg;
  logic        valid_reg;
  logic [7:0]  data_reg;

  // Tag comes from the issued address, so an address that moved mid-read refetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg   <= '0;
      iss_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (issue) iss_reg <= chan_addr;
      if (done) begin
        data_reg  <= dout;
        tag_reg   <= iss_reg;
        valid_reg <= 1'b1;
      end
    end
  end

  assign pend = !roe_n && (!valid_reg || chan_addr != tag_reg);
  assign data = data_reg;

endmodule

// File: rtl/jt10_adpcm_rom_arb.sv
// Round-robin arbiter sharing one byte-wide memory read port between the
// YM2610 ADPCM-A and ADPCM-B ROM interfaces.
module jt10_adpcm_rom_arb
  import jt10_rom_pkg::*;
#(
  parameter int            AW          = 25,
  parameter logic [AW-1:0] ADPCMA_BASE = AW'(DEF_ADPCMA_BASE),
  parameter logic [AW-1:0] ADPCMB_BASE = AW'(DEF_ADPCMB_BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [19:0]   adpcma_addr,
  input  logic [3:0]    adpcma_bank,
  input  logic          adpcma_roe_n,
  output logic [7:0]    adpcma_data,
  input  logic [23:0]   adpcmb_addr,
  input  logic          adpcmb_roe_n,
  output logic [7:0]    adpcmb_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          busy
);

  arb_state_t    state_reg, state_next;
  logic          last_grant_reg;
  logic [AW-1:0] mem_addr_reg;
  logic          grant_a, grant_b;
  logic          done_a, done_b;
  logic          pend_a, pend_b;
  logic [23:0]   chan_a;
  logic [AW-1:0] ea_a, ea_b;

  assign chan_a = {adpcma_bank, adpcma_addr};
  assign ea_a   = ADPCMA_BASE + AW'(chan_a);
  assign ea_b   = ADPCMB_BASE + AW'(adpcmb_addr);

  assign done_a = (state_reg == RD_A) && mem_ack;
  assign done_b = (state_reg == RD_B) && mem_ack;

  jt10_rom_chreq u_cha (
    .clk       (clk),
    .rst       (rst),
    .roe_n     (adpcma_roe_n),
    .chan_addr (chan_a),
    .issue     (grant_a),
    .done      (done_a),
    .dout      (mem_dout),
    .pend      (pend_a),
    .data      (adpcma_data)
  );

  jt10_rom_chreq u_chb (
    .clk       (clk),
    .rst       (rst),
    .roe_n     (adpcmb_roe_n),
    .chan_addr (adpcmb_addr),
    .issue     (grant_b),
    .done      (done_b),
    .dout      (mem_dout),
    .pend      (pend_b),
    .data      (adpcmb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_addr_reg   <= '0;
      last_grant_reg <= CH_B;
    end else begin
      state_reg <= state_next;
      if (grant_a)      mem_addr_reg <= ea_a;
      else if (grant_b) mem_addr_reg <= ea_b;
      if (done_a)       last_grant_reg <= CH_A;
      else if (done_b)  last_grant_reg <= CH_B;
    end
  end

  // Grants happen only from IDLE, which forces a low cycle on mem_req between reads.
  always_comb begin
    state_next = state_reg;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pend_a && (!pend_b || last_grant_reg == CH_B)) begin
          grant_a    = 1'b1;
          state_next = RD_A;
        end else if (pend_b) begin
          grant_b    = 1'b1;
          state_next = RD_B;
        end
      end
      RD_A:    if (mem_ack) state_next = IDLE;
      RD_B:    if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_req  = (state_reg != IDLE);
  assign busy     = (state_reg != IDLE);
  assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed self-checking bench for jt10_adpcm_rom_arb.
module tb_jt10_adpcm_rom_arb;
  import jt10_rom_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] adpcma_addr = '0;
  logic [3:0]  adpcma_bank = '0;
  logic        adpcma_roe_n = 1'b1;
  logic [7:0]  adpcma_data;
  logic [23:0] adpcmb_addr = '0;
  logic        adpcmb_roe_n = 1'b1;
  logic [7:0]  adpcmb_data;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        busy;

  logic [19:0] w_a_addr = '0;
  logic [3:0]  w_a_bank = '0;
  logic        w_a_roe_n = 1'b1;
  logic [7:0]  w_a_data;
  logic [23:0] w_b_addr = '0;
  logic        w_b_roe_n = 1'b1;
  logic [7:0]  w_b_data;
  logic [24:0] w_mem_addr;
  logic        w_mem_req;
  logic        w_mem_ack = 1'b0;
  logic [7:0]  w_mem_dout = '0;
  logic        w_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jt10_adpcm_rom_arb dut (
    .clk(clk), .rst(rst),
    .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank),
    .adpcma_roe_n(adpcma_roe_n), .adpcma_data(adpcma_data),
    .adpcmb_addr(adpcmb_addr), .adpcmb_roe_n(adpcmb_roe_n),
    .adpcmb_data(adpcmb_data),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_dout(mem_dout), .busy(busy)
  );

  jt10_adpcm_rom_arb #(.ADPCMB_BASE(25'h1FFFFFF)) dut_wrap (
    .clk(clk), .rst(rst),
    .adpcma_addr(w_a_addr), .adpcma_bank(w_a_bank),
    .adpcma_roe_n(w_a_roe_n), .adpcma_data(w_a_data),
    .adpcmb_addr(w_b_addr), .adpcmb_roe_n(w_b_roe_n),
    .adpcmb_data(w_b_data),
    .mem_addr(w_mem_addr), .mem_req(w_mem_req), .mem_ack(w_mem_ack),
    .mem_dout(w_mem_dout), .busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, check its address, hold it for delay cycles, then ack.
  task automatic serve(input string tag, input logic [24:0] exp_addr,
                       input logic [7:0] dout, input int delay);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, "_hold"}, 32'(mem_addr), 32'(exp_addr));
    end
    mem_dout = dout;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req",    32'(mem_req), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_addr",   32'(mem_addr), 32'd0);
    check("rst_adata",  32'(adpcma_data), 32'd0);
    check("rst_bdata",  32'(adpcmb_data), 32'd0);

    // Single A fetch, one-cycle latency, no refetch on unchanged address
    adpcma_bank  = 4'h2;
    adpcma_addr  = 20'h00010;
    adpcma_roe_n = 1'b0;
    tick();
    check("a1_latency", 32'(mem_req), 32'd1);
    serve("a1", 25'h0200010, 8'h5A, 0);
    check("a1_data", 32'(adpcma_data), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a1_norefetch", 32'(mem_req), 32'd0);
    end

    // Simultaneous pair after reset: A first, then B
    rst = 1'b1;
    adpcma_bank  = 4'h0;
    adpcma_addr  = 20'h0;
    adpcmb_addr  = 24'h000004;
    adpcmb_roe_n = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    serve("pair1_a", 25'h0000000, 8'h11, 1);
    serve("pair1_b", 25'h1000004, 8'h22, 1);
    check("pair1_adata", 32'(adpcma_data), 32'h11);
    check("pair1_bdata", 32'(adpcmb_data), 32'h22);
    // A-only fetch leaves A as last grant, so the next pair goes B first
    adpcma_addr = 20'h2;
    serve("aonly", 25'h0000002, 8'h33, 0);
    adpcma_addr = 20'h3;
    adpcmb_addr = 24'h000005;
    tick();
    serve("pair2_b", 25'h1000005, 8'h44, 0);
    serve("pair2_a", 25'h0000003, 8'h55, 0);
    check("pair2_adata", 32'(adpcma_data), 32'h55);
    check("pair2_bdata", 32'(adpcmb_data), 32'h44);

    // Address moves during RD_A: old read completes, then refetch after one idle cycle
    adpcmb_roe_n = 1'b1;
    do_reset();
    adpcma_addr = 20'h00010;
    tick();
    check("mv_req", 32'(mem_req), 32'd1);
    adpcma_addr = 20'h00011;
    serve("mv_old", 25'h0000010, 8'h66, 5);
    check("mv_old_data", 32'(adpcma_data), 32'h66);
    tick();
    check("mv_refetch_req", 32'(mem_req), 32'd1);
    serve("mv_new", 25'h0000011, 8'h77, 0);
    check("mv_new_data", 32'(adpcma_data), 32'h77);

    // Reset during RD_B, then a stray ack
    adpcmb_addr  = 24'h000008;
    adpcmb_roe_n = 1'b0;
    tick();
    check("rstb_req", 32'(mem_req), 32'd1);
    check("rstb_addr", 32'(mem_addr), 32'h1000008);
    rst = 1'b1;
    tick();
    check("rstb_req_drop", 32'(mem_req), 32'd0);
    check("rstb_busy", 32'(busy), 32'd0);
    check("rstb_bdata", 32'(adpcmb_data), 32'd0);
    adpcmb_roe_n = 1'b1;
    adpcma_roe_n = 1'b1;
    rst = 1'b0;
    mem_dout = 8'hFF;
    mem_ack  = 1'b1;
    tick();
    mem_ack  = 1'b0;
    check("stray_bdata", 32'(adpcmb_data), 32'd0);
    check("stray_adata", 32'(adpcma_data), 32'd0);
    check("stray_req", 32'(mem_req), 32'd0);

    // roe_n high: no requests, data held
    adpcmb_addr  = 24'h000010;
    adpcmb_roe_n = 1'b0;
    serve("hold_b", 25'h1000010, 8'hC3, 0);
    adpcmb_roe_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adpcmb_addr = 24'h000020 + 24'(i);
      tick();
      check("roe_noreq", 32'(mem_req), 32'd0);
    end
    check("roe_bdata", 32'(adpcmb_data), 32'hC3);

    // Base offset wrap on the alternate instance
    w_b_addr  = 24'h000002;
    w_b_roe_n = 1'b0;
    tick();
    check("wrap_req", 32'(w_mem_req), 32'd1);
    check("wrap_addr", 32'(w_mem_addr), 32'h0000001);
    w_mem_dout = 8'h9E;
    w_mem_ack  = 1'b1;
    tick();
    w_mem_ack  = 1'b0;
    check("wrap_data", 32'(w_b_data), 32'h9E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
